// File: rtl/systolic_array_top.sv
// systolic_array_top: memory-mapped Q1.15 matrix multiply on a 4x4 output-stationary
// systolic array. Define SYSTOLIC_SATURATE_EN to saturate results instead of wrapping.
module systolic_array_top #(
  parameter int INPUT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 16,
  parameter int FRAC_WIDTH   = 15,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addrA,
  input  logic                    enA,
  input  logic [INPUT_WIDTH-1:0]  dataA,
  input  logic [ADDR_WIDTH-1:0]   addrB,
  input  logic                    enB,
  input  logic [INPUT_WIDTH-1:0]  dataB,
  input  logic [ADDR_WIDTH-1:0]   addrI,
  input  logic                    enI,
  input  logic [INPUT_WIDTH-1:0]  dataI,
  input  logic [ADDR_WIDTH-1:0]   addrO,
  output logic [RESULT_WIDTH-1:0] dataO,
  input  logic                    ap_start,
  output logic                    ap_done
);
  localparam int PW    = 2 * INPUT_WIDTH;
  localparam int AW    = PW + 3;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // IDLE wait | FETCH read N | LOAD 4 tile rows | COMPUTE 10 skew cycles | WRITE drain 16 | NEXT step | DONE hold
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_LOAD = 3'd2, S_COMPUTE = 3'd3,
                         S_WRITE = 3'd4, S_NEXT = 3'd5, S_DONE = 3'd6;

  logic [INPUT_WIDTH-1:0]  mem_a [DEPTH];
  logic [INPUT_WIDTH-1:0]  mem_b [DEPTH];
  logic [INPUT_WIDTH-1:0]  mem_i [DEPTH];
  logic [RESULT_WIDTH-1:0] mem_o [DEPTH];

  logic [2:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ip_q, a_ptr_q, b_ptr_q, o_ptr_q;
  logic [INPUT_WIDTH-1:0]  n_q, rb_q, cb_q;
  logic [3:0]              cnt_q;
  logic                    done_q;
  logic [RESULT_WIDTH-1:0] dout_q;

  logic signed [INPUT_WIDTH-1:0] a_t_q  [4][4];
  logic signed [INPUT_WIDTH-1:0] b_t_q  [4][4];
  logic signed [INPUT_WIDTH-1:0] a_pe_q [4][4];
  logic signed [INPUT_WIDTH-1:0] b_pe_q [4][4];
  logic signed [AW-1:0]          acc_q  [4][4];
  logic signed [INPUT_WIDTH-1:0] a_in   [4][4];
  logic signed [INPUT_WIDTH-1:0] b_in   [4][4];
  logic signed [INPUT_WIDTH-1:0] a_ld   [4];
  logic signed [INPUT_WIDTH-1:0] b_ld   [4];
  logic signed [AW-1:0]          acc_sel;

  logic [INPUT_WIDTH-1:0]  instr;
  logic [31:0]             nb, row_ld, row_w, col_w;
  logic                    last_cb, last_rb, wr_en, host_wr;
  logic [ADDR_WIDTH-1:0]   o_addr;
  logic [RESULT_WIDTH-1:0] res;

  assign dataO   = dout_q;
  assign ap_done = done_q;
  assign host_wr = (state_q == S_IDLE) || (state_q == S_DONE);
  assign instr   = mem_i[ip_q];
  assign nb      = (32'(n_q) + 32'd3) >> 2;
  assign last_cb = (32'(cb_q) + 32'd1) >= nb;
  assign last_rb = (32'(rb_q) + 32'd1) >= nb;
  assign row_w   = 32'(rb_q) * 32'd4 + 32'(cnt_q[3:2]);
  assign col_w   = 32'(cb_q) * 32'd4 + 32'(cnt_q[1:0]);
  assign wr_en   = (state_q == S_WRITE) && (row_w < 32'(n_q)) && (col_w < 32'(n_q));
  assign o_addr  = o_ptr_q + ADDR_WIDTH'(row_w * 32'(n_q) + col_w);
  assign acc_sel = acc_q[cnt_q[3:2]][cnt_q[1:0]];

  // Missing A rows / B columns of edge tiles load as zero so their products vanish.
  always_comb begin
    row_ld = 32'(rb_q) * 32'd4 + 32'(cnt_q[1:0]);
    for (int k = 0; k < 4; k++) begin
      a_ld[k] = '0;
      b_ld[k] = '0;
      if (row_ld < 32'(n_q))
        a_ld[k] = mem_a[a_ptr_q + ADDR_WIDTH'(row_ld * 32'd4 + 32'(k))];
      if (32'(cb_q) * 32'd4 + 32'(k) < 32'(n_q))
        b_ld[k] = mem_b[b_ptr_q + ADDR_WIDTH'(32'(cnt_q[1:0]) * 32'(n_q) + 32'(cb_q) * 32'd4 + 32'(k))];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_in[i][0] = '0;
      b_in[0][i] = '0;
      if (cnt_q >= 4'(i) && cnt_q < 4'(i + 4)) begin
        a_in[i][0] = a_t_q[i][2'(cnt_q - 4'(i))];
        b_in[0][i] = b_t_q[2'(cnt_q - 4'(i))][i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 1; j < 4; j++) begin
        a_in[i][j] = a_pe_q[i][j-1];
        b_in[j][i] = b_pe_q[j-1][i];
      end
    end
  end

`ifdef SYSTOLIC_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (RESULT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [AW-1:0] acc_sh;
  always_comb begin
    acc_sh = acc_sel >>> FRAC_WIDTH;
    if (acc_sh > SAT_MAX)      res = SAT_MAX[RESULT_WIDTH-1:0];
    else if (acc_sh < SAT_MIN) res = SAT_MIN[RESULT_WIDTH-1:0];
    else                       res = acc_sh[RESULT_WIDTH-1:0];
  end
`else
  assign res = RESULT_WIDTH'(acc_sel >>> FRAC_WIDTH);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (ap_start) state_d = S_FETCH;
      S_FETCH:        state_d = (instr == '0 || ip_q == '1) ? S_DONE : S_LOAD;
      S_LOAD:         if (cnt_q == 4'd3) state_d = S_COMPUTE;
      S_COMPUTE:      if (cnt_q == 4'd9) state_d = S_WRITE;
      S_WRITE:        if (cnt_q == 4'd15) state_d = S_NEXT;
      S_NEXT:         state_d = (last_cb && last_rb) ? S_FETCH : S_LOAD;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ip_q    <= '0;
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      o_ptr_q <= '0;
      n_q     <= '0;
      rb_q    <= '0;
      cb_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_DONE);
      dout_q  <= mem_o[addrO];
      case (state_q)
        S_IDLE, S_DONE: if (ap_start) begin
          ip_q    <= '0;
          a_ptr_q <= '0;
          b_ptr_q <= '0;
          o_ptr_q <= '0;
        end
        S_FETCH: begin
          n_q   <= instr;
          rb_q  <= '0;
          cb_q  <= '0;
          cnt_q <= '0;
        end
        S_LOAD:    cnt_q <= (cnt_q == 4'd3) ? 4'd0 : cnt_q + 4'd1;
        S_COMPUTE: cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
        S_WRITE:   cnt_q <= cnt_q + 4'd1;
        S_NEXT: begin
          if (!last_cb) begin
            cb_q <= cb_q + INPUT_WIDTH'(1);
          end else if (!last_rb) begin
            rb_q <= rb_q + INPUT_WIDTH'(1);
            cb_q <= '0;
          end else begin
            ip_q    <= ip_q + ADDR_WIDTH'(1);
            a_ptr_q <= a_ptr_q + ADDR_WIDTH'(32'(n_q) * 32'd4);
            b_ptr_q <= b_ptr_q + ADDR_WIDTH'(32'(n_q) * 32'd4);
            o_ptr_q <= o_ptr_q + ADDR_WIDTH'(32'(n_q) * 32'(n_q));
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      for (int k = 0; k < 4; k++) begin
        a_t_q[cnt_q[1:0]][k] <= a_ld[k];
        b_t_q[cnt_q[1:0]][k] <= b_ld[k];
      end
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          a_pe_q[i][j] <= '0;
          b_pe_q[i][j] <= '0;
          acc_q[i][j]  <= '0;
        end
      end
    end else if (state_q == S_COMPUTE) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          a_pe_q[i][j] <= a_in[i][j];
          b_pe_q[i][j] <= b_in[i][j];
          acc_q[i][j]  <= acc_q[i][j] + AW'(PW'(a_in[i][j]) * PW'(b_in[i][j]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (host_wr && enA) mem_a[addrA] <= dataA;
    if (host_wr && enB) mem_b[addrB] <= dataB;
    if (host_wr && enI) mem_i[addrI] <= dataI;
    if (wr_en) mem_o[o_addr] <= res;
  end
endmodule

// File: tb/tb_systolic_array_top.sv
// tb_systolic_array_top: directed vectors for the matrix-multiply accelerator, with a
// shadow copy of all memories and a reference model for randomised programs.
`timescale 1ns/1ps
module tb_systolic_array_top;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  addrA = '0, addrB = '0, addrI = '0, addrO = '0;
  logic        enA = 1'b0, enB = 1'b0, enI = 1'b0;
  logic [15:0] dataA = '0, dataB = '0, dataI = '0;
  logic [15:0] dataO;
  logic        ap_start = 1'b0;
  logic        ap_done;

  int checks = 0;
  int failures = 0;

  logic [15:0] sh_a [1024];
  logic [15:0] sh_b [1024];
  logic [15:0] sh_i [1024];
  logic [15:0] sh_o [1024];

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [16];

`ifdef SYSTOLIC_SATURATE_EN
  localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h0000;
`endif

  systolic_array_top dut (
    .clk(clk), .rst(rst),
    .addrA(addrA), .enA(enA), .dataA(dataA),
    .addrB(addrB), .enB(enB), .dataB(dataB),
    .addrI(addrI), .enI(enI), .dataI(dataI),
    .addrO(addrO), .dataO(dataO),
    .ap_start(ap_start), .ap_done(ap_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input int sel, input int addr, input logic [15:0] d);
    case (sel)
      0: begin addrA = 10'(addr); dataA = d; enA = 1'b1; sh_a[addr] = d; end
      1: begin addrB = 10'(addr); dataB = d; enB = 1'b1; sh_b[addr] = d; end
      default: begin addrI = 10'(addr); dataI = d; enI = 1'b1; sh_i[addr] = d; end
    endcase
    @(posedge clk); #1;
    enA = 1'b0; enB = 1'b0; enI = 1'b0;
  endtask

  task automatic rd(input int addr, output logic [15:0] v);
    addrO = 10'(addr);
    @(posedge clk); #1;
    v = dataO;
  endtask

  task automatic run(input int limit, output int cyc);
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    cyc = 1;
    @(posedge clk); #1;
    cyc++;
    while (!ap_done && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("run_done", 32'(ap_done), 32'd1);
  endtask

  task automatic model_run();
    int ip = 0, ap = 0, bp = 0, op = 0, n;
    longint acc, s;
    bit fin = 1'b0;
    while (!fin) begin
      n = int'(sh_i[ip]);
      if (n == 0 || ip == 1023) begin
        fin = 1'b1;
      end else begin
        for (int r = 0; r < n; r++) begin
          for (int c = 0; c < n; c++) begin
            acc = 0;
            for (int k = 0; k < 4; k++)
              acc += longint'($signed(sh_a[(ap + 4*r + k) & 1023])) *
                     longint'($signed(sh_b[(bp + k*n + c) & 1023]));
            s = acc >>> 15;
`ifdef SYSTOLIC_SATURATE_EN
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
`endif
            sh_o[(op + r*n + c) & 1023] = s[15:0];
          end
        end
        ip++;
        ap = (ap + 4*n) & 1023;
        bp = (bp + 4*n) & 1023;
        op = (op + n*n) & 1023;
      end
    end
  endtask

  initial begin
    logic [15:0] v;
    int cyc;
    bit dropped, rose;

    vecs = '{'{10'd0, 16'h0800}, '{10'd1, 16'h0800}, '{10'd2, 16'h0800}, '{10'd3, 16'h0800},
             '{10'd4, 16'h1000}, '{10'd5, 16'h1000}, '{10'd6, 16'h1000}, '{10'd7, 16'h1000},
             '{10'd8, 16'h1800}, '{10'd9, 16'h1800}, '{10'd10, 16'h1800}, '{10'd11, 16'h1800},
             '{10'd12, 16'h2000}, '{10'd13, 16'h2000}, '{10'd14, 16'h2000}, '{10'd15, 16'h2000}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", 32'(ap_done), 32'd0);
    chk("reset_dataO", 32'(dataO), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Overflow: four products of 0x8000*0x8000 give 2^17 after the shift.
    for (int k = 0; k < 4; k++) begin
      wr(0, k, 16'h8000);
      wr(1, k, 16'h8000);
    end
    wr(2, 0, 16'd1);
    wr(2, 1, 16'd0);
    run(3000, cyc);
    model_run();
    rd(0, v);
    chk("ovf_o0", 32'(v), 32'(OVF_EXP));

    // N=1: 0.5 * 0.5 = 0.25
    wr(0, 0, 16'h4000);
    wr(1, 0, 16'h4000);
    for (int k = 1; k < 4; k++) begin
      wr(0, k, 16'h0000);
      wr(1, k, 16'h0000);
    end
    run(3000, cyc);
    model_run();
    rd(0, v);
    chk("n1_o0", 32'(v), 32'h2000);

    // N=4 data, then reset in the middle of COMPUTE
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        wr(0, 4*r + k, (r == k) ? 16'h4000 : 16'h0000);
        wr(1, 4*r + k, 16'(16'h1000 * (r + 1)));
      end
    end
    wr(2, 0, 16'd4);
    addrO = 10'd0;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_reset_dataO", 32'(dataO), 32'h2000);
    rst = 1'b0;
    #1;
    chk("async_rst_done", 32'(ap_done), 32'd0);
    chk("async_rst_dataO", 32'(dataO), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run(3000, cyc);
    model_run();
    for (int i = 0; i < 16; i++) begin
      rd(int'(vecs[i].addr), v);
      chk($sformatf("n4_o%0d", vecs[i].addr), 32'(v), 32'(vecs[i].exp));
    end

    // One-cycle read latency
    addrO = 10'd0;
    @(posedge clk); #1;
    addrO = 10'd15;
    @(negedge clk);
    chk("lat_hold", 32'(dataO), 32'h0800);
    @(posedge clk); #1;
    chk("lat_new", 32'(dataO), 32'h2000);

    // N=6 random: fills O[0..35], edge tiles in both directions
    for (int i = 0; i < 24; i++) begin
      wr(0, i, 16'($urandom));
      wr(1, i, 16'($urandom));
    end
    wr(2, 0, 16'd6);
    wr(2, 1, 16'd0);
    run(3000, cyc);
    model_run();

    // I=[2,5,0]: overwrites O[0..28], O[29..35] must keep the N=6 results
    for (int i = 0; i < 40; i++) begin
      wr(0, i, 16'($urandom));
      wr(1, i, 16'($urandom));
    end
    wr(2, 0, 16'd2);
    wr(2, 1, 16'd5);
    wr(2, 2, 16'd0);
    run(3000, cyc);
    model_run();
    for (int a = 0; a < 36; a++) begin
      rd(a, v);
      chk($sformatf("multi_o%0d", a), 32'(v), 32'(sh_o[a]));
    end

    // Empty program after a reset
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    wr(2, 0, 16'd0);
    run(20, cyc);
    chk("empty_latency_le4", 32'(cyc <= 4), 32'd1);
    rd(0, v);
    chk("empty_o0_kept", 32'(v), 32'(sh_o[0]));
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    dropped = 1'b0;
    for (int c = 0; c < 4 && !dropped; c++) begin
      @(posedge clk); #1;
      if (!ap_done) dropped = 1'b1;
    end
    chk("restart_done_drop", 32'(dropped), 32'd1);
    rose = 1'b0;
    for (int c = 0; c < 4 && !rose; c++) begin
      @(posedge clk); #1;
      if (ap_done) rose = 1'b1;
    end
    chk("restart_done_rise", 32'(rose), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
